// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH x DEPTH retiming register pipeline with per-stage valid bits and synchronous flush.
// Define DFF_PIPE_BACKPRESSURE_EN to add valid/ready backpressure with bubble collapsing.
module dff_pipe #(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] RST_VAL    = '0,
  parameter bit               RESET_DATA = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] valid;
  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH:0]   adv;
  logic             accept;
  logic             deliver;

`ifdef DFF_PIPE_BACKPRESSURE_EN
  // A stage may take a new beat if it is empty or its own content moves on;
  // the chain runs combinationally from out_ready back to in_ready.
  always_comb begin
    logic chain;
    chain      = out_ready;
    adv        = '0;
    adv[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain  = !valid[i] || chain;
      adv[i] = chain;
    end
  end
`else
  logic unused_out_ready;
  assign unused_out_ready = out_ready;
  assign adv = '1;
`endif

  assign in_ready  = !flush && adv[0];
  assign accept    = in_valid && in_ready;
  assign deliver   = valid[DEPTH-1] && adv[DEPTH];
  assign out_valid = valid[DEPTH-1];
  assign out_data  = data[DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid     <= '0;
      occupancy <= '0;
    end else begin
      if (adv[0]) valid[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) valid[i] <= valid[i-1];
      end
      if (accept && !deliver) occupancy <= occupancy + OCC_W'(1);
      else if (!accept && deliver) occupancy <= occupancy - OCC_W'(1);
    end
  end

  // Data only moves with a valid beat; bubbles leave the old value in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (RESET_DATA) begin
        for (int i = 0; i < DEPTH; i++) data[i] <= RST_VAL;
      end
    end else if (!flush) begin
      if (adv[0] && in_valid) data[0] <= in_data;
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i] && valid[i-1]) data[i] <= data[i-1];
      end
    end
  end

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: vector table, randomized traffic against a queue model,
// and backpressure corner sequences when DFF_PIPE_BACKPRESSURE_EN is defined.
module tb_dff_pipe;

  localparam int         WIDTH   = 8;
  localparam int         DEPTH   = 4;
  localparam logic [7:0] RST_VAL = 8'hA5;
`ifdef DFF_PIPE_BACKPRESSURE_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b1;
  logic [2:0] occupancy;

  always #5 clk = ~clk;

  dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RST_VAL), .RESET_DATA(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  typedef struct {
    logic [7:0] d;
    int         t;
  } beat_t;

  typedef struct {
    bit         rst, flush, iv;
    logic [7:0] d;
    bit         ordy, chk, e_ov, chk_d;
    logic [7:0] e_od;
    int         e_occ;
    bit         e_ir;
  } vec_t;

  beat_t q[$];
  vec_t  tbl[$];
  int    last_dlv = -100;
  bit    live = 1'b0;
  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic vec_t mk(bit r, bit f, bit iv, logic [7:0] d, bit ordy, bit chk,
                              bit e_ov, bit chk_d, logic [7:0] e_od, int e_occ, bit e_ir);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.d = d; v.ordy = ordy; v.chk = chk;
    v.e_ov = e_ov; v.chk_d = chk_d; v.e_od = e_od; v.e_occ = e_occ; v.e_ir = e_ir;
    return v;
  endfunction

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit f, input bit iv, input logic [7:0] d, input bit ordy);
    @(posedge clk);
    #1;
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  // Model: a beat accepted in cycle t reaches the output no earlier than t+DEPTH and
  // no earlier than one cycle after the previous beat left; occupancy is the queue size.
  task automatic checkOutput();
    bit         exp_ov, exp_ir, dlv;
    logic [7:0] exp_od;
    beat_t      b;
    @(negedge clk);
    exp_ov = 1'b0;
    exp_od = '0;
    if (q.size() > 0) begin
      exp_ov = (cyc >= imax(q[0].t + DEPTH, last_dlv + 1));
      exp_od = q[0].d;
    end
    exp_ir = !flush && (!BP || q.size() < DEPTH || out_ready);
    if (live) begin
      checkEq("model_out_valid", 32'(out_valid), 32'(exp_ov));
      if (exp_ov) checkEq("model_out_data", 32'(out_data), 32'(exp_od));
      checkEq("model_occupancy", 32'(occupancy), q.size());
      checkEq("model_in_ready", 32'(in_ready), 32'(exp_ir));
    end
    if (rst || flush) begin
      q.delete();
      if (rst) live = 1'b1;
    end else begin
      dlv = exp_ov && (!BP || out_ready);
      if (dlv) begin
        void'(q.pop_front());
        last_dlv = cyc;
      end
      if (in_valid && exp_ir) begin
        b.d = in_data;
        b.t = cyc;
        q.push_back(b);
      end
    end
    cyc++;
  endtask

  task automatic step(input bit r, input bit f, input bit iv, input logic [7:0] d, input bit ordy);
    applyStimulus(r, f, iv, d, ordy);
    checkOutput();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // rst, flush, iv, data, ordy | chk, ov, chk_d, od, occ, ir
    tbl.push_back(mk(1,0,0,8'h00,1, 0,0,0,8'h00,0,1));
    tbl.push_back(mk(1,0,0,8'h00,1, 1,0,1,8'hA5,0,1));
    tbl.push_back(mk(0,0,1,8'h01,1, 1,0,1,8'hA5,0,1));
    tbl.push_back(mk(0,0,1,8'h02,1, 1,0,1,8'hA5,1,1));
    tbl.push_back(mk(0,0,1,8'h03,1, 1,0,1,8'hA5,2,1));
    tbl.push_back(mk(0,0,1,8'h04,1, 1,0,1,8'hA5,3,1));
    tbl.push_back(mk(0,0,1,8'h05,1, 1,1,1,8'h01,4,1));
    tbl.push_back(mk(0,0,1,8'h06,1, 1,1,1,8'h02,4,1));
    tbl.push_back(mk(0,0,1,8'h07,1, 1,1,1,8'h03,4,1));
    tbl.push_back(mk(0,0,1,8'h08,1, 1,1,1,8'h04,4,1));
    tbl.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'h05,4,1));
    tbl.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'h06,3,1));
    tbl.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'h07,2,1));
    tbl.push_back(mk(0,0,1,8'h09,1, 1,1,1,8'h08,1,1));
    tbl.push_back(mk(0,0,1,8'h0A,1, 1,0,0,8'h00,1,1));
    tbl.push_back(mk(0,0,1,8'h0B,1, 1,0,0,8'h00,2,1));
    tbl.push_back(mk(0,1,1,8'h0C,1, 1,0,0,8'h00,3,0));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,0,0,8'h00,1, 1,0,0,8'h00,0,1));
    tbl.push_back(mk(0,0,1,8'hD1,1, 1,0,0,8'h00,0,1));
    tbl.push_back(mk(0,0,1,8'hD2,1, 1,0,0,8'h00,1,1));
    tbl.push_back(mk(1,1,1,8'hD3,1, 1,0,0,8'h00,2,0));
    tbl.push_back(mk(0,0,1,8'hE1,1, 1,0,1,8'hA5,0,1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0,0,0,8'h00,1, 1,0,1,8'hA5,1,1));
    tbl.push_back(mk(0,0,0,8'h00,1, 1,1,1,8'hE1,1,1));
    tbl.push_back(mk(0,0,0,8'h00,1, 1,0,0,8'h00,0,1));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      if (tbl[i].chk) begin
        checkEq("tbl_out_valid", 32'(out_valid), 32'(tbl[i].e_ov));
        if (tbl[i].chk_d) checkEq("tbl_out_data", 32'(out_data), 32'(tbl[i].e_od));
        checkEq("tbl_occupancy", 32'(occupancy), 32'(tbl[i].e_occ));
        checkEq("tbl_in_ready", 32'(in_ready), 32'(tbl[i].e_ir));
      end
    end

    for (int i = 0; i < 600; i++) begin
      step($urandom_range(99) == 0, $urandom_range(19) == 0, $urandom_range(9) < 7,
           8'($urandom), $urandom_range(9) < 6);
    end

`ifdef DFF_PIPE_BACKPRESSURE_EN
    begin
      int         idx, acc, sent;
      logic [7:0] got[$];
      step(1, 0, 0, 8'h00, 1);
      idx = 1;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
        step(0, 0, 1, 8'(idx), 0);
        if (in_ready) begin
          acc++;
          idx++;
        end
      end
      checkEq("bp_fill_accepts", acc, 4);
      checkEq("bp_fill_occupancy", 32'(occupancy), 4);
      checkEq("bp_fill_in_ready", 32'(in_ready), 0);
      checkEq("bp_fill_head", 32'(out_data), 32'h01);
      for (int i = 0; i < 30 && got.size() < 6; i++) begin
        sent = (idx <= 6) ? 1 : 0;
        step(0, 0, sent != 0, 8'(idx), 1);
        if (out_valid) got.push_back(out_data);
        if (in_ready && sent != 0) idx++;
      end
      checkEq("bp_release_count", got.size(), 6);
      foreach (got[k]) checkEq("bp_release_order", 32'(got[k]), k + 1);

      step(0, 1, 0, 8'h00, 1);
      step(0, 0, 1, 8'hB1, 0);
      step(0, 0, 0, 8'h00, 0);
      step(0, 0, 0, 8'h00, 0);
      step(0, 0, 1, 8'hB2, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00, 0);
      checkEq("bp_collapse_occupancy", 32'(occupancy), 2);
      checkEq("bp_collapse_valid", 32'(out_valid), 1);
      checkEq("bp_collapse_head", 32'(out_data), 32'hB1);
      step(0, 0, 0, 8'h00, 1);
      step(0, 0, 0, 8'h00, 0);
      checkEq("bp_collapse_second_valid", 32'(out_valid), 1);
      checkEq("bp_collapse_second", 32'(out_data), 32'hB2);
      step(0, 0, 0, 8'h00, 1);
      step(0, 0, 0, 8'h00, 1);
      checkEq("bp_collapse_drained", 32'(occupancy), 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
